uart_mode_ctrl: RTL
===================

# uart_mode_ctrl

Byte-stream command parser between the UART receiver and the SEG/PWM/LED outputs. Bytes outside command mode pass through as display data. A framed command `M <ch> <rate> F` sets a per-channel rate code for NUM_CH independent PWM/LED channels. Malformed or stalled commands are aborted with an error pulse.

## Interface
- NUM_CH, 4, number of rate channels (1..10; channel digits '0'..'0'+NUM_CH-1)
- RATE_W, 2, rate-code width per channel (≥2)
- TIMEOUT_CYC, 50_000_000, idle cycles allowed inside a command before abort (≥2)
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- i_valid  in  1  one-cycle strobe: i_data holds a received byte
- i_data  in  8  received byte
- o_data  out  8  last pass-through data byte
- o_data_valid  out  1  one-cycle pulse when o_data updates
- o_rate  out  NUM_CH*RATE_W  rate codes; channel k at bits [k*RATE_W +: RATE_W]
- o_start  out  1  1 = normal mode (state IDLE), 0 = command in progress
- o_commit  out  1  one-cycle pulse when a rate update is applied
- o_err  out  1  one-cycle pulse on command abort

## Operation
- States: IDLE, GET_CH, GET_RATE, WAIT_END. Transitions occur only on cycles with i_valid=1, except timeout.
- IDLE:
  - 'M'/'m' (0x4D/0x6D) -> GET_CH.
  - 0x00, 'F'/'f' (0x46/0x66): ignored.
  - Any other byte is data: o_data <= i_data, o_data_valid pulses, stay IDLE.
- GET_CH:
  - Byte '0'+k with k<NUM_CH -> latch ch=k, -> GET_RATE.
  - Any other byte -> o_err, IDLE.
- GET_RATE, decode to pending rate, then -> WAIT_END:
  - '1' (0x31) -> 0.
  - '5' (0x35) -> 1.
  - 'A'/'a' (0x41/0x61) -> 2.
  - Any other byte -> all-ones (RATE_W'b11…1).
- WAIT_END:
  - 'F'/'f' -> write pending rate into channel ch, o_commit pulses, -> IDLE.
  - 'M'/'m' -> discard pending, -> GET_CH (restart, no o_err).
  - Other bytes -> ignored.
- Timeout: a counter clears on entry to GET_CH and on every accepted i_valid. It increments every cycle in non-IDLE states. When it reaches TIMEOUT_CYC-1: o_err pulses, state -> IDLE, pending discarded, o_rate unchanged. Counter width is $clog2(TIMEOUT_CYC).
- o_rate fields change only on commit; other channels hold.
- o_data holds its value until the next data byte; command bytes never alter it.

## Timing
- Reset values: state=IDLE, o_data=0x00, o_data_valid=0, o_rate=all zero, o_start=1, o_commit=0, o_err=0, counter=0.
- Reset takes priority over every input in the same cycle. Reset mid-command discards the command; committed rates return to 0.
- All outputs are registered.
- i_valid at cycle n -> o_data_valid / o_commit / o_err high at cycle n+1 for exactly one cycle. New o_data / o_rate are visible at n+1.
- o_start reflects the registered state: it falls at n+1 after 'M' and rises at n+1 after 'F' or an abort.
- Back-to-back i_valid every cycle must be accepted with no byte loss.
- Timeout vs. i_valid in the same cycle: the byte wins and the counter clears.
- o_err and o_commit are mutually exclusive.

## Test plan
- Reset, then i_data 'H' (0x48) with i_valid -> next cycle o_data=0x48, o_data_valid=1 for one cycle, o_start=1, o_rate=0.
- Bytes 'm','2','5','F' on consecutive cycles (NUM_CH=4, RATE_W=2) -> o_start=0 from cycle 2 to cycle 4. o_commit at cycle 5, o_rate=8'b00_01_00_00, o_start=1. o_data unchanged.
- 'M','0','Z','x','f' -> o_rate[1:0]=2'b11 after 'f'. The 'x' byte is ignored and o_data_valid never pulses.
- 'M','7' with NUM_CH=4 -> o_err pulse one cycle after '7', state IDLE, o_rate unchanged. Then 'Q' -> o_data=0x51.
- TIMEOUT_CYC=8: 'M','1' then no input -> o_err exactly 8 cycles after the last byte's state entry, o_start returns to 1, no commit.
- 'M','3','A' then reset=1 for one cycle alongside 'F' -> all outputs at reset values and no o_commit. Then a full 'M','3','A','F' -> o_rate[7:6]=2'b10.

Source files
------------

// File: rtl/uart_mode_ctrl.sv
// Purpose : UART byte-stream parser; passes data bytes through and decodes "M <ch> <rate> F" rate commands.
// Latency : 1 cycle, byte accepted at cycle n -> registered outputs/pulses at n+1.
// Backpressure: none, a byte is accepted on every i_valid cycle, including back-to-back.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   i_valid, i_data       one-cycle byte strobe from the UART receiver
//   o_data, o_data_valid  last pass-through byte and its one-cycle update pulse
//   o_rate                per-channel rate codes, channel k at [k*RATE_W +: RATE_W]
//   o_start               1 while idle (normal mode), 0 while a command is in progress
//   o_commit, o_err       one-cycle pulses: rate written / command aborted
module uart_mode_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int RATE_W      = 2,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_valid,
    input  logic [7:0]                 i_data,
    output logic [7:0]                 o_data,
    output logic                       o_data_valid,
    output logic [NUM_CH*RATE_W-1:0]   o_rate,
    output logic                       o_start,
    output logic                       o_commit,
    output logic                       o_err
);

    localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       CH_LIMIT = 8'(NUM_CH);

    typedef enum logic [1:0] {
        IDLE,
        GET_CH,
        GET_RATE,
        WAIT_END
    } state_t;

    state_t                     state, state_nxt;
    logic [CH_W-1:0]            ch, ch_nxt;
    logic [RATE_W-1:0]          pend, pend_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    logic [7:0]                 data_nxt;
    logic                       data_valid_nxt;
    logic [NUM_CH*RATE_W-1:0]   rate_nxt;
    logic                       commit_nxt;
    logic                       err_nxt;

    logic                       is_m;
    logic                       is_f;
    logic [7:0]                 digit;
    logic                       digit_ok;
    logic [RATE_W-1:0]          rate_code;

    assign is_m     = (i_data == 8'h4D) || (i_data == 8'h6D);
    assign is_f     = (i_data == 8'h46) || (i_data == 8'h66);
    assign digit    = i_data - 8'h30;
    // Lower bound checked on the raw byte so the subtraction cannot wrap into range.
    assign digit_ok = (i_data >= 8'h30) && (digit < CH_LIMIT);

    always_comb begin
        rate_code = '1;
        case (i_data)
            8'h31:        rate_code = RATE_W'(0);
            8'h35:        rate_code = RATE_W'(1);
            8'h41, 8'h61: rate_code = RATE_W'(2);
            default:      rate_code = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ch           <= '0;
            pend         <= '0;
            cnt          <= '0;
            o_data       <= 8'h00;
            o_data_valid <= 1'b0;
            o_rate       <= '0;
            o_start      <= 1'b1;
            o_commit     <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            state        <= state_nxt;
            ch           <= ch_nxt;
            pend         <= pend_nxt;
            cnt          <= cnt_nxt;
            o_data       <= data_nxt;
            o_data_valid <= data_valid_nxt;
            o_rate       <= rate_nxt;
            o_start      <= (state_nxt == IDLE);
            o_commit     <= commit_nxt;
            o_err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ch_nxt         = ch;
        pend_nxt       = pend;
        cnt_nxt        = cnt;
        data_nxt       = o_data;
        data_valid_nxt = 1'b0;
        rate_nxt       = o_rate;
        commit_nxt     = 1'b0;
        err_nxt        = 1'b0;

        if (i_valid) begin
            // Any accepted byte restarts the idle window, which also covers
            // the clear on entry to GET_CH (always entered via a byte).
            cnt_nxt = '0;
            case (state)
                IDLE: begin
                    if (is_m) begin
                        state_nxt = GET_CH;
                    end else if (!(is_f || (i_data == 8'h00))) begin
                        data_nxt       = i_data;
                        data_valid_nxt = 1'b1;
                    end
                end
                GET_CH: begin
                    if (digit_ok) begin
                        ch_nxt    = digit[CH_W-1:0];
                        state_nxt = GET_RATE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                GET_RATE: begin
                    pend_nxt  = rate_code;
                    state_nxt = WAIT_END;
                end
                WAIT_END: begin
                    if (is_f) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (ch == CH_W'(k)) begin
                                rate_nxt[k*RATE_W +: RATE_W] = pend;
                            end
                        end
                        commit_nxt = 1'b1;
                        state_nxt  = IDLE;
                    end else if (is_m) begin
                        pend_nxt  = '0;
                        state_nxt = GET_CH;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE) begin
            // A byte in the same cycle takes the branch above, so a byte
            // arriving exactly at the limit still wins over the abort.
            if (cnt == CNT_LAST) begin
                err_nxt   = 1'b1;
                state_nxt = IDLE;
                pend_nxt  = '0;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

endmodule
